// File: rtl/paddle_motion.sv
// Paddle controller: per-tick motion with a hold-to-accelerate speed ramp, hard clamping
// at both playfield limits, and an auto mode that tracks the ball for a CPU player.
module paddle_motion #(
  parameter int unsigned POS_W        = 9,
  parameter int unsigned HEIGHT       = 40,
  parameter int unsigned MIN_POS      = 0,
  parameter int unsigned MAX_POS      = 240,
  parameter int unsigned START_POS    = 100,
  parameter int unsigned MAX_SPEED    = 4,
  parameter int unsigned AI_MAX_SPEED = 2,
  parameter int unsigned ACCEL_TICKS  = 4,
  parameter int unsigned AI_DEADBAND  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             mode,
  input  logic             up,
  input  logic             down,
  input  logic [POS_W-1:0] ball_pos,
  output logic [POS_W-1:0] paddle_pos,
  output logic [3:0]       speed,
  output logic             at_top,
  output logic             at_bottom
);

  // One spare bit so sums and differences near the limits never wrap.
  localparam int unsigned ExtW  = POS_W + 1;
  localparam int unsigned HoldW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic [ExtW-1:0]  TopPos   = ExtW'(MAX_POS - HEIGHT);
  localparam logic [ExtW-1:0]  BotPos   = ExtW'(MIN_POS);
  localparam logic [ExtW-1:0]  HalfH    = ExtW'(HEIGHT / 2);
  localparam logic [ExtW-1:0]  Deadband = ExtW'(AI_DEADBAND);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(ACCEL_TICKS - 1);
  localparam logic [3:0]       ManCap   = 4'(MAX_SPEED);
  localparam logic [3:0]       AutoCap  = 4'(AI_MAX_SPEED);
  localparam logic [POS_W-1:0] StartPos = POS_W'(START_POS);
  localparam logic             StartTop = (START_POS == MAX_POS - HEIGHT);
  localparam logic             StartBot = (START_POS == MIN_POS);

  typedef enum logic [1:0] {StIdle, StMovePos, StMoveNeg} state_e;
  typedef enum logic [1:0] {DirNone, DirPos, DirNeg} dir_e;

  state_e           state_q, state_d;
  dir_e             dir;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [3:0]       speed_d;
  logic [3:0]       cap;
  logic [ExtW-1:0]  pos_ext, pos_d, centre, ball_ext, step_ext;
  logic             mode_q;

  assign pos_ext  = {1'b0, paddle_pos};
  assign ball_ext = {1'b0, ball_pos};
  assign centre   = pos_ext + HalfH;
  assign cap      = mode ? AutoCap : ManCap;

  always_comb begin
    dir = DirNone;
    if (mode) begin
      if (ball_ext > centre + Deadband) begin
        dir = DirPos;
      end else if (ball_ext + Deadband < centre) begin
        dir = DirNeg;
      end
    end else if (up && !down) begin
      dir = DirPos;
    end else if (down && !up) begin
      dir = DirNeg;
    end
  end

  always_comb begin
    state_d  = StIdle;
    speed_d  = 4'd0;
    hold_d   = '0;
    pos_d    = pos_ext;
    step_ext = '0;
    // A mode switch costs one idle tick regardless of the inputs.
    if (mode == mode_q && dir != DirNone) begin
      state_d = (dir == DirPos) ? StMovePos : StMoveNeg;
      if (state_q == state_d) begin
        if (hold_q == HoldLast) begin
          hold_d  = '0;
          speed_d = (speed >= cap) ? cap : speed + 4'd1;
        end else begin
          hold_d  = hold_q + 1'b1;
          speed_d = speed;
        end
      end else begin
        speed_d = 4'd1;
        hold_d  = '0;
      end
      step_ext = ExtW'(speed_d);
      if (dir == DirPos) begin
        if (pos_ext + step_ext >= TopPos) begin
          pos_d   = TopPos;
          speed_d = 4'd1;
          hold_d  = '0;
        end else begin
          pos_d = pos_ext + step_ext;
        end
      end else begin
        if (pos_ext < BotPos + step_ext) begin
          pos_d   = BotPos;
          speed_d = 4'd1;
          hold_d  = '0;
        end else begin
          pos_d = pos_ext - step_ext;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      mode_q     <= mode;
      paddle_pos <= StartPos;
      speed      <= 4'd0;
      at_top     <= StartTop;
      at_bottom  <= StartBot;
    end else if (tick) begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      mode_q     <= mode;
      paddle_pos <= pos_d[POS_W-1:0];
      speed      <= speed_d;
      at_top     <= (pos_d == TopPos);
      at_bottom  <= (pos_d == BotPos);
    end
  end

endmodule

// File: tb/tb_paddle_motion.sv
// Directed bench for paddle_motion with hand-computed positions and speeds (default parameters).
module tb_paddle_motion;

  logic       clock = 1'b0;
  logic       reset, tick, mode, up, down;
  logic [8:0] ball_pos;
  logic [8:0] paddle_pos;
  logic [3:0] speed;
  logic       at_top, at_bottom;

  int total = 0;
  int bad   = 0;

  paddle_motion dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .mode       (mode),
    .up         (up),
    .down       (down),
    .ball_pos   (ball_pos),
    .paddle_pos (paddle_pos),
    .speed      (speed),
    .at_top     (at_top),
    .at_bottom  (at_bottom)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_ps(input string tag, input int p, input int s);
    check({tag, ".pos"}, 16'(paddle_pos), 16'(p));
    check({tag, ".speed"}, 16'(speed), 16'(s));
  endtask

  // Apply one tick with the given manual buttons; outputs sampled 1ns after the edge.
  task automatic step(input logic u, input logic d);
    up   = u;
    down = d;
    tick = 1'b1;
    @(posedge clock);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  int up_pos[10]   = '{101, 102, 103, 104, 106, 108, 110, 112, 115, 118};
  int up_spd[10]   = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
  int top_pos[11]  = '{181, 182, 183, 184, 186, 188, 190, 192, 195, 198, 200};
  int top_spd[11]  = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 1};
  int bot_pos[10]  = '{16, 15, 14, 13, 11, 9, 7, 5, 2, 0};
  int bot_spd[10]  = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 1};
  int ai_pos[9]    = '{101, 102, 103, 104, 106, 108, 110, 112, 114};
  int ai_spd[9]    = '{1, 1, 1, 1, 2, 2, 2, 2, 2};

  initial begin
    reset = 1'b1; tick = 1'b0; mode = 1'b0; up = 1'b0; down = 1'b0; ball_pos = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_ps("reset", 100, 0);
    check("reset.at_top", 16'(at_top), 16'd0);
    check("reset.at_bottom", 16'(at_bottom), 16'd0);

    // Ramp while up is held, with an idle gap of non-tick cycles.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      check_ps($sformatf("ramp%0d", i), up_pos[i], up_spd[i]);
      if (i == 4) begin
        repeat (5) @(posedge clock);
        #1;
        check_ps("notick", 106, 2);
      end
    end

    // Run to the top limit at full speed.
    repeat (20) step(1'b1, 1'b0);
    check_ps("run", 196, 4);
    step(1'b1, 1'b0);
    check_ps("topclamp", 200, 1);
    check("topclamp.at_top", 16'(at_top), 16'd1);
    step(1'b1, 1'b0);
    check_ps("topstay", 200, 1);

    // Walk down to 180 at speed 1, then approach the top with speed 3.
    repeat (5) begin
      repeat (4) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    check_ps("at180", 180, 0);
    check("at180.at_top", 16'(at_top), 16'd0);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0);
      check_ps($sformatf("top%0d", i), top_pos[i], top_spd[i]);
    end
    check("top.at_top", 16'(at_top), 16'd1);

    // Walk down to 17, then approach the bottom with speed 3.
    repeat (15) begin
      repeat (8) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_ps("at17", 17, 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      check_ps($sformatf("bot%0d", i), bot_pos[i], bot_spd[i]);
    end
    check("bot.at_bottom", 16'(at_bottom), 16'd1);
    step(1'b0, 1'b1);
    check_ps("botstay", 0, 1);
    step(1'b1, 1'b1);
    check_ps("both", 0, 0);
    check("both.at_bottom", 16'(at_bottom), 16'd1);

    // Reversal after reaching speed 2.
    repeat (6) step(1'b1, 1'b0);
    check_ps("rev.pre", 8, 2);
    step(1'b0, 1'b1);
    check_ps("rev", 7, 1);

    // Reset mid-move at speed 3, with tick also asserted.
    do_reset();
    check_ps("reset2", 100, 0);
    repeat (9) step(1'b1, 1'b0);
    check_ps("premv", 115, 3);
    reset = 1'b1;
    step(1'b1, 1'b0);
    reset = 1'b0;
    check_ps("resetmv", 100, 0);

    // Auto mode: switch tick idles, deadband, capped tracking.
    mode = 1'b1;
    ball_pos = 9'd121;
    step(1'b1, 1'b0);
    check_ps("ai.switch", 100, 0);
    step(1'b1, 1'b0);
    check_ps("ai.dead", 100, 0);
    ball_pos = 9'd200;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1);
      check_ps($sformatf("ai%0d", i), ai_pos[i], ai_spd[i]);
    end
    ball_pos = 9'd132;
    step(1'b0, 1'b0);
    check_ps("ai.deadlo", 114, 0);
    ball_pos = 9'd131;
    step(1'b0, 1'b0);
    check_ps("ai.neg", 113, 1);
    ball_pos = 9'd137;
    step(1'b0, 1'b0);
    check_ps("ai.pos", 114, 1);

    // Back to manual: one idle tick, then normal motion.
    mode = 1'b0;
    step(1'b1, 1'b0);
    check_ps("man.switch", 114, 0);
    step(1'b1, 1'b0);
    check_ps("man.move", 115, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paddle_motion.md
Name: paddle_motion

Overview:
Successor paddle controller for the Pong playfield. Moves one paddle along its axis once per frame tick, with a speed ramp while a direction is held and hard clamping at both playfield limits. Adds a selectable auto mode that tracks the ball position for a CPU-controlled player. Sits between the input debouncers or ball logic and the collision/renderer blocks, which consume paddle_pos.

Parameters:
POS_W, 9, width of position buses in bits
HEIGHT, 40, paddle length in pixels along the motion axis
MIN_POS, 0, lowest legal paddle_pos
MAX_POS, 240, playfield extent; highest legal paddle_pos is MAX_POS-HEIGHT
START_POS, 100, paddle_pos after reset
MAX_SPEED, 4, manual-mode speed ceiling in pixels/tick (1..15)
AI_MAX_SPEED, 2, auto-mode speed ceiling (1..MAX_SPEED)
ACCEL_TICKS, 4, consecutive same-direction ticks per speed increment (>=1)
AI_DEADBAND, 2, auto-mode tolerance around the paddle centre, in pixels

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle frame enable; all state updates only when tick=1
mode  in  1  0 = manual (up/down), 1 = auto (track ball_pos)
up  in  1  manual request: increase position
down  in  1  manual request: decrease position
ball_pos  in  POS_W  ball coordinate on the paddle axis (auto mode only)
paddle_pos  out  POS_W  paddle low edge, registered
speed  out  4  speed applied on the last tick, registered
at_top  out  1  paddle_pos == MAX_POS-HEIGHT, registered
at_bottom  out  1  paddle_pos == MIN_POS, registered

Behaviour:
- Reset is synchronous, active-high, and takes priority over tick. Reset values: paddle_pos=START_POS, speed=0, state=IDLE, hold counter=0, mode_q=mode. at_top and at_bottom are set from START_POS.
- When tick=0, all registers hold their values.
- Latency: a tick in cycle n produces updated outputs visible in cycle n+1.
- Requested direction (dir) is evaluated on each tick:
  - Manual: up&!down gives POS; down&!up gives NEG; both or neither gives NONE.
  - Auto: centre = paddle_pos + HEIGHT/2, computed at POS_W+1 bits. ball_pos > centre+AI_DEADBAND gives POS. ball_pos < centre-AI_DEADBAND gives NEG. Otherwise NONE.
- FSM states: IDLE, MOVE_POS, MOVE_NEG.
  - dir=NONE: go to IDLE, speed=0, hold=0, no motion.
  - Entering a move from IDLE, or reversing direction: speed=1, hold=0.
  - Same direction as the current state: if hold==ACCEL_TICKS-1, then hold=0 and speed=min(speed+1, cap); else hold+1.
  - cap = MAX_SPEED in manual mode, AI_MAX_SPEED in auto mode.
- Mode change: mode is registered into mode_q on each tick. On the tick where mode != mode_q, the FSM is forced to IDLE with speed=0 and no motion, whatever the inputs. Normal evaluation resumes on the next tick.
- Motion uses the new speed on the same tick. All arithmetic is done at POS_W+1 bits so the result never wraps.
  - POS: if paddle_pos+speed >= MAX_POS-HEIGHT, then paddle_pos=MAX_POS-HEIGHT, speed=1, hold=0 (clamp). Otherwise paddle_pos+=speed.
  - NEG: if paddle_pos < MIN_POS+speed, then paddle_pos=MIN_POS, speed=1, hold=0 (clamp). Otherwise paddle_pos-=speed.
  - The clamp rule applies on every tick the paddle is pushed into a limit, including when it is already there.
- at_top and at_bottom are recomputed from the next paddle_pos in the same update.
- Auto mode ignores up/down. Manual mode ignores ball_pos.

Test Plan:
(All scenarios use default parameters; top limit is 200.)
- Reset → paddle_pos=100, speed=0, at_top=0, at_bottom=0. Assert reset during a move with speed=3 → next cycle paddle_pos=100, speed=0.
- Manual up held for 10 ticks from 100 → speeds 1,1,1,1,2,2,2,2,3,3; final paddle_pos=118. With tick=0 for 5 cycles between ticks → no change.
- Up held from 195 with speed 3 → paddle_pos=198, then clamps to 200 with speed=1 and at_top=1. Further up ticks → stays at 200, speed=1.
- Down from 2 with speed 3 → paddle_pos=0, speed=1, at_bottom=1, no wrap to 511. Then up&down together → speed=0, position unchanged.
- Reversal: after 6 up ticks (speed 2), press down → next tick speed=1 and paddle_pos decreases by 1.
- Auto mode with paddle_pos=100: the first tick after switching gives no motion and speed=0. With ball_pos=200 → moves POS with speed capped at 2. With ball_pos=121 (within deadband of centre 120) → IDLE, speed=0.
